dg0045_rom_server: RTL and testbench

DG0045_ROM_SERVER -- requirements
Module: dg0045_rom_server

---
 rtl/dg0045_pkg.sv | 16 +
 rtl/dg0045_rom_1kx8.sv | 29 ++
 rtl/dg0045_rom_server.sv | 126 ++++++++++++
 tb/tb_dg0045_rom_server.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dg0045_pkg.sv
// Shared types and constants for the ROM server: scan states, address widths
// and the opcode served before any real read has completed.
package dg0045_pkg;

   localparam int PC_W   = 10;
   localparam int HALF_W = 5;

   localparam logic [7:0] NOP = 8'h00;

   typedef enum logic [1:0] {
      S_LO  = 2'd0,
      S_HI  = 2'd1,
      S_CMP = 2'd2
   } scan_state_e;

endpackage

// File: rtl/dg0045_rom_1kx8.sv
// 1024x8 single-port program memory with registered read data and no reset.
// Read data only changes on a read access, so it holds the last fetched byte.
module dg0045_rom_1kx8
   import dg0045_pkg::*;
(
   input  logic            clk,
   input  logic            en_i,
   input  logic            we_i,
   input  logic [PC_W-1:0] addr_i,
   input  logic [7:0]      wdata_i,
   output logic [7:0]      rdata_o
);

   logic [7:0] mem_q [1024];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dg0045_rom_server.sv
// Serves instruction bytes to a core that exposes its PC in two multiplexed
// halves; the PC is scanned, stability-filtered, and the addressed byte fetched.
module dg0045_rom_server
   import dg0045_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [HALF_W-1:0] pc_hl,
   output logic              pc_mux,
   output logic [7:0]        rom_data,
   output logic [PC_W-1:0]   cur_addr,
   output logic              addr_stb,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [PC_W-1:0]   ld_addr,
   input  logic [7:0]        ld_data
);

   localparam logic [2:0] SETTLE_C = 3'(SETTLE);

   scan_state_e       state_q;
   logic [2:0]        cnt_q;
   logic              pc_mux_q;
   logic [HALF_W-1:0] lo_q;
   logic [HALF_W-1:0] hi_q;
   logic [PC_W-1:0]   prev_q;
   logic              prev_vld_q;
   logic              refresh_q;
   logic [PC_W-1:0]   cur_addr_q;
   logic              addr_stb_q;
   logic              rom_vld_q;

   logic [PC_W-1:0]   cand_d;
   logic              in_cmp;
   logic              rd_issue;
   logic              wr_fire;
   logic [PC_W-1:0]   mem_addr;
   logic [7:0]        mem_rdata;

   assign cand_d = {hi_q, lo_q};
   assign in_cmp = (state_q == S_CMP);

   // The very first scan after reset has nothing to compare against, so a
   // match is only trusted once a previous candidate has really been captured.
   assign rd_issue = rst_n && in_cmp && prev_vld_q && (cand_d == prev_q) &&
                     ((cand_d != cur_addr_q) || refresh_q);

   assign ld_ready = rst_n && !in_cmp;
   assign wr_fire  = ld_valid && ld_ready;
   assign mem_addr = wr_fire ? ld_addr : cand_d;

   dg0045_rom_1kx8 u_rom (
      .clk     (clk),
      .en_i    (rd_issue || wr_fire),
      .we_i    (wr_fire),
      .addr_i  (mem_addr),
      .wdata_i (ld_data),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_LO;
         cnt_q      <= 3'd0;
         pc_mux_q   <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         refresh_q  <= 1'b1;
         cur_addr_q <= '0;
         addr_stb_q <= 1'b0;
         rom_vld_q  <= 1'b0;
      end else begin
         addr_stb_q <= rd_issue;
         if (wr_fire && (ld_addr == cur_addr_q)) begin
            refresh_q <= 1'b1;
         end
         case (state_q)
            S_LO: begin
               if (cnt_q == SETTLE_C) begin
                  lo_q     <= pc_hl;
                  cnt_q    <= 3'd0;
                  pc_mux_q <= 1'b1;
                  state_q  <= S_HI;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            S_HI: begin
               if (cnt_q == SETTLE_C) begin
                  hi_q     <= pc_hl;
                  cnt_q    <= 3'd0;
                  pc_mux_q <= 1'b0;
                  state_q  <= S_CMP;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            S_CMP: begin
               prev_q     <= cand_d;
               prev_vld_q <= 1'b1;
               state_q    <= S_LO;
               if (rd_issue) begin
                  cur_addr_q <= cand_d;
                  refresh_q  <= 1'b0;
                  rom_vld_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_LO;
               cnt_q   <= 3'd0;
            end
         endcase
      end
   end

   // Memory read data is not reset, so a NOP is shown until the first fetch.
   assign rom_data = rom_vld_q ? mem_rdata : NOP;
   assign pc_mux   = pc_mux_q;
   assign cur_addr = cur_addr_q;
   assign addr_stb = addr_stb_q;

endmodule

// File: tb/tb_dg0045_rom_server.sv
// Randomized bench for dg0045_rom_server: a core model answers pc_mux, and a
// phase-counting reference model predicts every output on every cycle.
module tb_dg0045_rom_server;
   import dg0045_pkg::*;

   localparam int S   = 3;
   localparam int L   = 2 * S + 3;
   localparam int CMP = 2 * S + 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] pc = 10'h000;
   logic [4:0] pc_hl;
   logic       pc_mux;
   logic [7:0] rom_data;
   logic [9:0] cur_addr;
   logic       addr_stb;
   logic       ld_valid = 1'b0;
   logic       ld_ready;
   logic [9:0] ld_addr = 10'h000;
   logic [7:0] ld_data = 8'h00;

   always #5 clk = ~clk;

   // Core model: presents the requested half of its program counter.
   assign pc_hl = pc_mux ? pc[9:5] : pc[4:0];

   dg0045_rom_server #(.SETTLE(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pc_hl    (pc_hl),
      .pc_mux   (pc_mux),
      .rom_data (rom_data),
      .cur_addr (cur_addr),
      .addr_stb (addr_stb),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data)
   );

   // Reference model state: position within the scan plus the served values.
   int         ph;
   bit         known = 1'b0;
   bit         quiet = 1'b0;
   logic [4:0] m_lo, m_hi;
   logic [9:0] m_prev, m_cur;
   bit         m_pvld, m_refresh, m_stb;
   logic [7:0] m_rom;
   logic [7:0] m_mem [1024];

   int n_checks = 0;
   int n_errors = 0;
   int n_stb    = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit e_ready();
      return (rst_n == 1'b1) && (ph != CMP);
   endfunction

   task automatic model_edge();
      logic [9:0] cand;
      if (!rst_n) begin
         ph = 0; m_lo = '0; m_hi = '0; m_prev = '0; m_pvld = 1'b0;
         m_refresh = 1'b1; m_cur = '0; m_rom = 8'h00; m_stb = 1'b0;
         known = 1'b1;
         return;
      end
      if (!known) return;
      m_stb = 1'b0;
      if (ld_valid && e_ready()) begin
         m_mem[ld_addr] = ld_data;
         if (ld_addr == m_cur) m_refresh = 1'b1;
         if (!quiet) $display("write addr=%03h data=%02h", ld_addr, ld_data);
      end
      if (ph == S)     m_lo = pc[4:0];
      if (ph == 2*S+1) m_hi = pc[9:5];
      if (ph == CMP) begin
         cand = {m_hi, m_lo};
         if (m_pvld && cand == m_prev && (cand != m_cur || m_refresh)) begin
            m_cur = cand; m_rom = m_mem[cand]; m_stb = 1'b1; m_refresh = 1'b0;
         end
         m_prev = cand;
         m_pvld = 1'b1;
      end
      ph = (ph + 1) % L;
   endtask

   // One clock: check outputs mid-cycle, advance the model, step past the edge.
   task automatic cycle();
      @(negedge clk);
      if (known) begin
         check_eq("pc_mux",   32'(pc_mux),   32'(ph > S && ph <= 2*S+1));
         check_eq("ld_ready", 32'(ld_ready), 32'(e_ready()));
         check_eq("rom_data", 32'(rom_data), 32'(m_rom));
         check_eq("cur_addr", 32'(cur_addr), 32'(m_cur));
         check_eq("addr_stb", 32'(addr_stb), 32'(m_stb));
         if (addr_stb === 1'b1) begin
            n_stb++;
            $display("read  addr=%03h data=%02h", cur_addr, rom_data);
         end
      end
      model_edge();
      @(posedge clk);
      #1;
   endtask

   int held_cycles = 0;

   task automatic write_byte(input logic [9:0] a, input logic [7:0] d);
      bit acc;
      int tries;
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 8) begin
         acc = known && e_ready();
         if (!acc) held_cycles++;
         cycle();
         tries++;
      end
      if (!acc) check_eq("write_timeout", 32'(acc), 32'd1);
      ld_valid = 1'b0;
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < L && ph != p; i++) cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         s0;
      logic [9:0] saved;

      rst_n = 1'b0;
      repeat (3) cycle();
      check_eq("reset_rom",  32'(rom_data), 32'h00);
      check_eq("reset_addr", 32'(cur_addr), 32'h000);
      rst_n = 1'b1;

      // Fill every location; ld_valid stays high through any S_CMP cycle.
      quiet = 1'b1;
      for (int a = 0; a < 1024; a++) write_byte(10'(a), 8'($urandom));
      quiet = 1'b0;
      check_eq("held_across_cmp", 32'(held_cycles > 0), 32'd1);

      // Boot with PC stuck at 0: first read at the second S_CMP, then silence.
      pc = 10'h000;
      rst_n = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
      s0 = n_stb;
      repeat (2 * L) cycle();
      check_eq("boot_no_early_stb", 32'(n_stb - s0), 32'd0);
      cycle();
      check_eq("boot_stb_2nd_cmp", 32'(n_stb - s0), 32'd1);
      check_eq("boot_rom", 32'(rom_data), 32'(m_mem[0]));
      repeat (3 * L) cycle();
      check_eq("boot_single_stb", 32'(n_stb - s0), 32'd1);

      // Load a byte then jump to it.
      write_byte(10'h2A5, 8'hC3);
      pc = 10'h2A5;
      s0 = n_stb;
      repeat (4 * L) cycle();
      check_eq("jump_rom",  32'(rom_data), 32'hC3);
      check_eq("jump_addr", 32'(cur_addr), 32'h2A5);
      check_eq("jump_stb",  32'(n_stb - s0), 32'd1);

      // PC changes after lo is sampled but before hi is sampled.
      pc = 10'h040;
      repeat (4 * L) cycle();
      wait_phase(S + 1);
      pc = 10'h3C0;
      s0 = n_stb;
      wait_phase(0);
      cycle();
      check_eq("torn_no_stb",  32'(n_stb - s0), 32'd0);
      check_eq("torn_hold",    32'(cur_addr), 32'h040);
      repeat (3 * L) cycle();
      check_eq("torn_settled", 32'(cur_addr), 32'h3C0);
      check_eq("torn_one_stb", 32'(n_stb - s0), 32'd1);

      // Random PC traffic with concurrent loads, including a 0x3FF -> 0x000 wrap.
      for (int it = 0; it < 60; it++) begin
         int hold;
         pc = (it == 10) ? 10'h3FF : (it == 11) ? 10'h000 : 10'($urandom);
         hold = (it == 10 || it == 11) ? 3 * L : int'($urandom_range(1, 2 * L));
         for (int j = 0; j < hold; j++) begin
            if ($urandom_range(0, 3) == 0) begin
               ld_valid = 1'b1;
               ld_addr  = ($urandom_range(0, 1) == 0) ? m_cur : 10'($urandom);
               ld_data  = 8'($urandom);
            end else begin
               ld_valid = 1'b0;
            end
            cycle();
         end
      end
      ld_valid = 1'b0;

      // Rewrite the byte under the current address; it must be re-fetched.
      repeat (3 * L) cycle();
      saved = m_cur;
      write_byte(saved, 8'h55);
      s0 = n_stb;
      repeat (2 * L) cycle();
      check_eq("refresh_rom",  32'(rom_data), 32'h55);
      check_eq("refresh_addr", 32'(cur_addr), 32'(saved));
      check_eq("refresh_stb",  32'(n_stb - s0), 32'd1);

      // One-cycle reset in the middle of S_HI; memory must survive.
      pc = 10'h123;
      repeat (3 * L) cycle();
      wait_phase(S + 2);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check_eq("midrst_rom",  32'(rom_data), 32'h00);
      check_eq("midrst_addr", 32'(cur_addr), 32'h000);
      check_eq("midrst_mux",  32'(pc_mux), 32'd0);
      check_eq("midrst_stb",  32'(addr_stb), 32'd0);
      repeat (2 * L + 1) cycle();
      check_eq("midrst_mem",  32'(rom_data), 32'(m_mem[10'h123]));
      check_eq("midrst_cur",  32'(cur_addr), 32'h123);
      repeat (2 * L) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
